// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : uart_rx
// Brief    : UART receiver. Takes a 16x oversampling tick, samples each bit at
//            mid-bit, and reports parity and framing status. The parity bit is
//            included only when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 sample_tick,
    input  logic                 p_sel,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_tick_w-1:0] c_half_last = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_full_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
`endif
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [1:0]           r_sync;
    logic                 r_rxs_prev;
    logic                 w_rxs;
    logic                 w_fall;
    logic                 w_half_done;
    logic                 w_bit_done;
    logic [2:0]           r_state;
    logic [c_tick_w-1:0]  r_tcnt;
    logic [c_bit_w-1:0]   r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

`ifdef UART_RX_PARITY_EN
    logic                 r_psel;
    logic                 r_par_pend;
    logic                 r_parity_err;
    logic                 w_par_exp;

    assign w_par_exp  = r_psel ? ~^r_shift : ^r_shift;
    assign parity_err = r_parity_err;
`else
    logic                 w_unused_p_sel;

    assign w_unused_p_sel = p_sel;
    assign parity_err     = 1'b0;
`endif

    assign w_rxs       = r_sync[1];
    assign w_fall      = r_rxs_prev & ~w_rxs;
    assign w_half_done = sample_tick && (r_tcnt == c_half_last);
    assign w_bit_done  = sample_tick && (r_tcnt == c_full_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_rxs_prev   <= 1'b1;
            r_state      <= c_st_idle;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_psel       <= 1'b0;
            r_par_pend   <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_rxs_prev <= w_rxs;
            r_rx_valid <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_fall) begin
                        r_state <= c_st_start;
                        r_tcnt  <= '0;
                    end
                end

                // Mid-start check rejects glitches shorter than half a bit.
                c_st_start: begin
                    if (w_half_done) begin
                        r_tcnt <= '0;
                        if (!w_rxs) begin
                            r_state <= c_st_data;
                            r_bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                            r_psel     <= p_sel;
                            r_par_pend <= 1'b0;
`endif
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else if (sample_tick) begin
                        r_tcnt <= r_tcnt + c_tick_one;
                    end
                end

                c_st_data: begin
                    if (w_bit_done) begin
                        r_tcnt          <= '0;
                        r_shift[r_bcnt] <= w_rxs;
                        if (r_bcnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_st_parity;
`else
                            r_state <= c_st_stop;
`endif
                        end else begin
                            r_bcnt <= r_bcnt + c_bit_one;
                        end
                    end else if (sample_tick) begin
                        r_tcnt <= r_tcnt + c_tick_one;
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_st_parity: begin
                    if (w_bit_done) begin
                        r_tcnt     <= '0;
                        r_par_pend <= (w_rxs != w_par_exp);
                        r_state    <= c_st_stop;
                    end else if (sample_tick) begin
                        r_tcnt <= r_tcnt + c_tick_one;
                    end
                end
`endif

                // Leaving at mid-stop lets a directly following start bit be seen.
                c_st_stop: begin
                    if (w_bit_done) begin
                        r_tcnt      <= '0;
                        r_data      <= r_shift;
                        r_frame_err <= ~w_rxs;
                        r_rx_valid  <= 1'b1;
                        r_state     <= c_st_idle;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_pend;
`endif
                    end else if (sample_tick) begin
                        r_tcnt <= r_tcnt + c_tick_one;
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign data_out  = r_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire
